bcd_gray: RTL and testbench
===========================

// Module: bcd_gray
//
// PURPOSE
// - Converts one 4-bit BCD digit {a,x,y,z} (a = MSB) to its 4-bit reflected
//   Gray code {e,f,g,h} (e = MSB).
// - Registered conversion stage, gated by enable i.
// - Flags non-BCD codes (10..15) on err.
// - Sits in the display/encoder datapath between BCD counters and
//   Gray-coded consumers.
//
// PARAMETERS
// - none (fixed 4-bit digit width)
//
// PORTS
// clk   input  1  single clock; all state updates on rising edge
// rst   input  1  reset, synchronous and active-high
// a     input  1  BCD bit 3 (MSB)
// x     input  1  BCD bit 2
// y     input  1  BCD bit 1
// z     input  1  BCD bit 0 (LSB)
// i     input  1  enable: 1 = capture and convert, 0 = hold
// e     output 1  Gray bit 3 (MSB)
// f     output 1  Gray bit 2
// g     output 1  Gray bit 1
// h     output 1  Gray bit 0 (LSB)
// err   output 1  1 = last captured input was not valid BCD (>9)
//
// BEHAVIOUR
// Gray mapping (combinational):
// - e = a
// - f = a^x
// - g = x^y
// - h = y^z
//
// Reset:
// - On a clk edge with rst=1, e,f,g,h,err <= 0, regardless of i.
// - rst has priority over i.
//
// Enable:
// - On a clk edge with rst=0 and i=1, {e,f,g,h} <= gray({a,x,y,z}).
// - On the same edge, err <= ({a,x,y,z} > 4'd9).
// - Latency is exactly 1 clock from input sample to output.
// - On a clk edge with rst=0 and i=0, all outputs hold their previous values.
//
// Invalid BCD (10..15):
// - Gray outputs are still the plain binary-to-Gray of the 4 bits.
// - err = 1 for that captured value.
//
// General:
// - Inputs changing between edges have no effect; outputs change only on
//   clk edges. There are no combinational paths from inputs to outputs.
// - Reset asserted mid-stream clears the outputs on that edge. The first
//   i=1 edge after reset release loads the new value.
//
// STRUCTURE
// - Shared package bcd_pkg:
//   - typedef logic [3:0] digit_t
//   - constant BCD_MAX = 4'd9
//   - function bin2gray(digit_t)
// - One natural sub-module, bin2gray4: a purely combinational 4-bit
//   converter. The top module holds the 5 output flops and the enable/reset
//   muxing.
//
// TESTING
// - rst=1 for 2 edges, any inputs -> e,f,g,h,err = 0000,0.
// - rst=0, i=0, abxyz=1000 -> outputs stay 0000,0.
// - i=1, {a,x,y,z}=1000 (8) -> next edge {e,f,g,h}=1100, err=0.
// - i=1, {a,x,y,z}=1110 (14) -> next edge {e,f,g,h}=1001, err=1.
// - i=1, {a,x,y,z}=1101 (13) -> 1011, err=1.
//   Then i=0 with input 0000 -> outputs hold 1011,1.
// - Sweep 0..9 with i=1 -> 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101
//   with err=0. Assert rst during the sweep -> 0000,0 on that edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-Gray conversion stage.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

    // Reflected binary Gray: each bit is the XOR of itself and the next-higher bit.
    function automatic digit_t bin2gray(digit_t bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bcd_gray_if.sv
// Digit-in / Gray-out signal bundle for bcd_gray.
interface bcd_gray_if;

    logic a;
    logic x;
    logic y;
    logic z;
    logic i;
    logic e;
    logic f;
    logic g;
    logic h;
    logic err;

    modport master (
        output a, x, y, z, i,
        input  e, f, g, h, err
    );

    modport slave (
        input  a, x, y, z, i,
        output e, f, g, h, err
    );

endinterface

// File: rtl/bin2gray4.sv
// Purely combinational 4-bit binary to reflected Gray converter.
module bin2gray4
    import bcd_pkg::*;
(
    input  digit_t bin_i,
    output digit_t gray_o
);

    assign gray_o = bin2gray(bin_i);

endmodule

// File: rtl/bcd_gray.sv
// Registered BCD digit to Gray conversion with enable and non-BCD flag.
module bcd_gray
    import bcd_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bcd_gray_if.slave    bus
);

    digit_t din;
    digit_t gray;
    digit_t gray_d, gray_q;
    logic   err_d, err_q;

    assign din = {bus.a, bus.x, bus.y, bus.z};

    bin2gray4 u_bin2gray4 (
        .bin_i  (din),
        .gray_o (gray)
    );

    always_comb begin
        gray_d = gray_q;
        err_d  = err_q;
        if (bus.i) begin
            gray_d = gray;
            err_d  = (din > BCD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
            err_q  <= 1'b0;
        end else begin
            gray_q <= gray_d;
            err_q  <= err_d;
        end
    end

    assign bus.e   = gray_q[3];
    assign bus.f   = gray_q[2];
    assign bus.g   = gray_q[1];
    assign bus.h   = gray_q[0];
    assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_gray.sv
// Directed bench for bcd_gray: reset, enable/hold, invalid codes, sweep with mid-sweep reset.
module tb_bcd_gray;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    bcd_gray_if bus ();

    bcd_gray dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] eg, input logic ee);
        logic [4:0] obs;
        logic [4:0] exp_v;
        obs   = {bus.e, bus.f, bus.g, bus.h, bus.err};
        exp_v = {eg, ee};
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: efgh,err got %b,%b expected %b,%b",
                    tag, obs[4:1], obs[0], exp_v[4:1], exp_v[0]);
    endtask

    // Drive on the falling edge, check 1 time unit after the next rising edge.
    task automatic step(input logic [3:0] d, input logic en, input logic r,
                        input logic [3:0] eg, input logic ee, input string tag);
        @(negedge clk);
        rst = r;
        bus.i = en;
        {bus.a, bus.x, bus.y, bus.z} = d;
        @(posedge clk);
        #1;
        check(tag, eg, ee);
    endtask

    logic [3:0] gtab [0:9];

    initial begin
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        bus.i = 1'b1;
        {bus.a, bus.x, bus.y, bus.z} = 4'b1111;

        step(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, "reset_edge1");
        step(4'b1010, 1'b1, 1'b1, 4'b0000, 1'b0, "reset_edge2");
        step(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, "hold_after_reset");
        step(4'b1000, 1'b1, 1'b0, 4'b1100, 1'b0, "load_8");
        step(4'b1110, 1'b1, 1'b0, 4'b1001, 1'b1, "load_14");
        step(4'b1101, 1'b1, 1'b0, 4'b1011, 1'b1, "load_13");
        step(4'b0000, 1'b0, 1'b0, 4'b1011, 1'b1, "hold_13_a");
        step(4'b0101, 1'b0, 1'b0, 4'b1011, 1'b1, "hold_13_b");

        // Inputs changing between edges must not reach the outputs.
        @(negedge clk);
        bus.i = 1'b1;
        {bus.a, bus.x, bus.y, bus.z} = 4'b0011;
        #1;
        check("no_comb_path", 4'b1011, 1'b1);
        @(posedge clk);
        #1;
        check("load_3", 4'b0010, 1'b0);

        step(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, "load_15");
        step(4'b1010, 1'b1, 1'b0, 4'b1111, 1'b1, "load_10");
        step(4'b1001, 1'b1, 1'b0, 4'b1101, 1'b0, "load_9_clears_err");
        step(4'b1100, 1'b1, 1'b0, 4'b1010, 1'b1, "load_12");
        step(4'b1011, 1'b1, 1'b0, 4'b1110, 1'b1, "load_11");

        for (int k = 0; k < 5; k++)
            step(4'(k), 1'b1, 1'b0, gtab[k], 1'b0, $sformatf("sweep_%0d", k));
        step(4'd5, 1'b1, 1'b1, 4'b0000, 1'b0, "sweep_reset");
        for (int k = 5; k < 10; k++)
            step(4'(k), 1'b1, 1'b0, gtab[k], 1'b0, $sformatf("sweep_%0d", k));

        // Reset with enable low also clears.
        step(4'b0110, 1'b0, 1'b1, 4'b0000, 1'b0, "reset_enable_low");
        step(4'b0110, 1'b1, 1'b0, 4'b0101, 1'b0, "first_load_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
